usr_serial_rx: RTL and testbench
================================

Name: usr_serial_rx

Overview:
- Serial-to-parallel receiver that forms the far end of the universal shift register's serial shift path.
- Samples one bit per qualified clock into a shift register, with MSB-first (left-shift) or LSB-first (right-shift) ordering.
- After WIDTH bits, presents the assembled word on a valid/ready output with a one-word holding buffer.
- Sits between a shift register's serial output and a parallel consumer.

Parameters:
- WIDTH, 8, word length in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is sampled on this edge.
- dir  input  1  0 = MSB-first (left shift), 1 = LSB-first (right shift); latched at the first bit of each word.
- frame_start  input  1  synchronous discard of any partial word; realigns to a word boundary.
- ovr_clr  input  1  clears the overrun flag.
- data_out  output  WIDTH  assembled word.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out when data_valid=1.
- busy  output  1  a partial word is in progress.
- overrun  output  1  sticky: a completed word was dropped.
- bit_count  output  CNT_W  number of bits received in the current word.

Behaviour:
- Reset (clr_n=0, asynchronous) forces the following:
  - state=IDLE; shift reg, bit_count and data_out = 0.
  - data_valid, busy and overrun = 0.
  - The latched direction = 0.
- State machine has two states:
  - IDLE: busy=0. A bit_valid moves the block to SHIFT, latches dir, shifts the bit in and sets bit_count=1.
  - SHIFT: busy=1. Each bit_valid shifts one bit in and increments bit_count. When bit_valid arrives with bit_count==WIDTH-1, the word completes: go to IDLE and set bit_count=0.
- Shift rules use the direction latched at word start; dir changes mid-word are ignored.
  - Latched dir=0: sh <= {sh[WIDTH-2:0], bit_in}. The first bit received ends up in the MSB.
  - Latched dir=1: sh <= {bit_in, sh[WIDTH-1:1]}. The first bit received ends up in the LSB.
- Idle cycles (bit_valid=0) are allowed between bits; state is held.
- Word completion:
  - The completed word is the shift-reg value including the final bit.
  - It loads data_out and sets data_valid=1 on the same edge that samples the final bit. Latency is therefore 0 cycles after the final bit's edge.
  - The load happens if data_valid=0, or if data_valid=1 and data_ready=1 in that cycle (the buffer is being drained).
  - Otherwise the word is dropped: overrun<=1, data_out is unchanged, and the receiver still returns to IDLE.
- Output handshake:
  - A transfer occurs when data_valid & data_ready are both 1.
  - After a transfer, data_valid clears unless a new word loads on the same edge.
  - data_out is stable while data_valid=1 and no transfer occurs.
- frame_start:
  - Sets state=IDLE and bit_count=0, and clears the shift reg. data_out and data_valid are unaffected.
  - If bit_valid is asserted in the same cycle, that bit becomes bit 1 of a new word: state=SHIFT, bit_count=1, dir latched from the current input.
- overrun:
  - Set by a dropped word. Cleared by ovr_clr or reset.
  - If set and clear occur in the same cycle, set wins.
- Reset asserted mid-word discards the partial word and any buffered word.

Decomposition:
- A shared package usr_pkg holds:
  - the state encoding (ST_IDLE, ST_SHIFT);
  - the direction constants DIR_MSB_FIRST=0 and DIR_LSB_FIRST=1 (also used by the shift-register controller).
- One natural sub-module, usr_rx_buf: the one-word valid/ready holding register with load, drain and overrun detection.

Test Plan:
- MSB-first, dir=0: send bits 0,1,1,1,0,0,1,1 with data_ready=1 -> data_out=8'h73 and data_valid=1 on the 8th bit's edge; bit_count sequence 1..7, then 0.
- LSB-first, dir=1: send bits 1,1,0,0,1,1,1,0 with random bit_valid gaps -> data_out=8'h73. Toggling dir after bit 3 has no effect.
- Backpressure, data_ready=0: send 8'hA5 then 8'h3C -> data_out holds 8'hA5 and overrun=1. Then raise data_ready and pulse ovr_clr -> data_valid=0, overrun=0.
- Drain and load on the same edge: word 8'h0F is pending, and data_ready=1 on the final bit of 8'hF0 -> data_out=8'hF0, data_valid stays 1, overrun=0.
- frame_start after 3 bits, asserted together with bit_valid (bit_in=1), then 7 more bits of 8'b1000_0001 MSB-first -> data_out=8'h81.
- clr_n pulsed low after 5 bits -> all outputs 0 immediately. A following full word 8'hC3 is received correctly.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register serial path (receiver and controller).
// No logic; types and constants only.
package usr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } usr_rx_state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/usr_rx_buf.sv
// One-word valid/ready holding register; a word loads on the same edge it is offered.
// Accepts when empty or being drained; otherwise drops the word and sets sticky overrun.
module usr_rx_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load_vld,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             ovr_clr,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] dat_q, dat_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;
    logic             can_load;

    assign can_load = !vld_q || data_ready;

    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        ovr_d = ovr_q;
        if (load_vld && can_load) begin
            dat_d = load_dat;
            vld_d = 1'b1;
        end else if (vld_q && data_ready) begin
            vld_d = 1'b0;
        end
        // A drop in the same cycle as a clear must leave the flag set.
        if (load_vld && !can_load) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            dat_q <= '0;
            vld_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
            ovr_q <= ovr_d;
        end
    end

    assign data_out   = dat_q;
    assign data_valid = vld_q;
    assign overrun    = ovr_q;

endmodule

// File: rtl/usr_serial_rx.sv
// Serial-to-parallel receiver: MSB- or LSB-first word assembly into a one-word output buffer.
// Word is presented on the edge that samples its final bit; a full, undrained buffer drops it.
module usr_serial_rx
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             dir,
    input  logic             frame_start,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    usr_rx_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             dir_q, dir_d;

    usr_rx_state_t    cur_state;
    logic [CNT_W-1:0] cur_cnt;
    logic [WIDTH-1:0] cur_sh;
    logic [WIDTH-1:0] shifted;
    logic             dir_use;
    logic             word_vld;
    logic [WIDTH-1:0] word_dat;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        dir_d    = dir_q;
        word_vld = 1'b0;
        word_dat = '0;

        // frame_start realigns first, so a bit on the same edge starts a new word.
        cur_state = frame_start ? ST_IDLE : state_q;
        cur_cnt   = frame_start ? '0 : cnt_q;
        cur_sh    = frame_start ? '0 : sh_q;
        dir_use   = (cur_state == ST_IDLE) ? dir : dir_q;
        shifted   = (dir_use == DIR_LSB_FIRST) ? {bit_in, cur_sh[WIDTH-1:1]}
                                               : {cur_sh[WIDTH-2:0], bit_in};

        if (frame_start) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sh_d    = '0;
        end

        if (bit_valid) begin
            case (cur_state)
                ST_IDLE: begin
                    dir_d   = dir;
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_W'(1);
                    sh_d    = shifted;
                end
                ST_SHIFT: begin
                    if (cur_cnt == LAST_CNT) begin
                        word_vld = 1'b1;
                        word_dat = shifted;
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                        sh_d     = '0;
                    end else begin
                        cnt_d = cur_cnt + CNT_W'(1);
                        sh_d  = shifted;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            dir_q   <= DIR_MSB_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dir_q   <= dir_d;
        end
    end

    usr_rx_buf #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk        (clk),
        .clr_n      (clr_n),
        .load_vld   (word_vld),
        .load_dat   (word_dat),
        .ovr_clr    (ovr_clr),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun)
    );

    assign busy      = (state_q == ST_SHIFT);
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_usr_serial_rx.sv
// Directed bench for usr_serial_rx (WIDTH=8) with hand-computed expected words.
module tb_usr_serial_rx;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       bit_in;
    logic       bit_valid;
    logic       dir;
    logic       frame_start;
    logic       ovr_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       busy;
    logic       overrun;
    logic [2:0] bit_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    usr_serial_rx #(.WIDTH(8)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .dir         (dir),
        .frame_start (frame_start),
        .ovr_clr     (ovr_clr),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .busy        (busy),
        .overrun     (overrun),
        .bit_count   (bit_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Sends transmission-order bits first..first+n-1 of word w for the given order.
    task automatic send_bits(input logic [7:0] w, input logic lsb_first, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            send_bit(lsb_first ? w[i] : w[7-i]);
        end
    endtask

    initial begin
        clr_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; dir = 1'b0;
        frame_start = 1'b0; ovr_clr = 1'b0; data_ready = 1'b1;
        #12;
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_bit_count", bit_count, 3'd0);
        clr_n = 1'b1;
        idle();

        // MSB-first 0x73 with bit_count progression
        dir = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_bits(8'h73, 1'b0, i, 1);
            chk("msb_bit_count", bit_count, 32'(i + 1));
            chk("msb_busy", busy, 1'b1);
        end
        send_bits(8'h73, 1'b0, 7, 1);
        chk("msb_data_out", data_out, 8'h73);
        chk("msb_data_valid", data_valid, 1'b1);
        chk("msb_bit_count_wrap", bit_count, 3'd0);
        chk("msb_busy_done", busy, 1'b0);
        idle();
        chk("msb_drained", data_valid, 1'b0);

        // LSB-first 0x73 with random gaps; dir flips after bit 3 must not matter
        dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_bits(8'h73, 1'b1, i, 1);
            if (i == 2) dir = 1'b0;
            if (i < 7) repeat ($urandom_range(0, 2)) idle();
        end
        chk("lsb_data_out", data_out, 8'h73);
        chk("lsb_data_valid", data_valid, 1'b1);
        idle();

        // Backpressure: second word dropped, first word held
        data_ready = 1'b0;
        dir = 1'b0;
        send_bits(8'hA5, 1'b0, 0, 8);
        chk("bp_first_out", data_out, 8'hA5);
        chk("bp_first_ovr", overrun, 1'b0);
        send_bits(8'h3C, 1'b0, 0, 8);
        chk("bp_hold_out", data_out, 8'hA5);
        chk("bp_hold_valid", data_valid, 1'b1);
        chk("bp_overrun", overrun, 1'b1);
        chk("bp_idle_after_drop", busy, 1'b0);
        data_ready = 1'b1;
        ovr_clr = 1'b1;
        idle();
        ovr_clr = 1'b0;
        chk("bp_drained", data_valid, 1'b0);
        chk("bp_ovr_cleared", overrun, 1'b0);

        // Drain and load on the same edge
        data_ready = 1'b0;
        send_bits(8'h0F, 1'b0, 0, 8);
        chk("dl_pending", data_out, 8'h0F);
        send_bits(8'hF0, 1'b0, 0, 7);
        chk("dl_still_held", data_out, 8'h0F);
        data_ready = 1'b1;
        send_bits(8'hF0, 1'b0, 7, 1);
        chk("dl_data_out", data_out, 8'hF0);
        chk("dl_data_valid", data_valid, 1'b1);
        chk("dl_overrun", overrun, 1'b0);
        idle();
        chk("dl_drained", data_valid, 1'b0);

        // frame_start together with bit_valid starts a new word
        send_bits(8'hA0, 1'b0, 0, 3);
        chk("fs_pre_count", bit_count, 3'd3);
        frame_start = 1'b1;
        send_bit(1'b1);
        chk("fs_count", bit_count, 3'd1);
        chk("fs_busy", busy, 1'b1);
        chk("fs_no_word", data_valid, 1'b0);
        send_bits(8'h81, 1'b0, 1, 7);
        chk("fs_data_out", data_out, 8'h81);
        chk("fs_data_valid", data_valid, 1'b1);
        idle();

        // Asynchronous reset mid-word with a word buffered
        data_ready = 1'b0;
        send_bits(8'h55, 1'b0, 0, 8);
        chk("ar_buffered", data_valid, 1'b1);
        send_bits(8'hFF, 1'b0, 0, 5);
        #2;
        clr_n = 1'b0;
        #1;
        chk("ar_data_out", data_out, 8'h00);
        chk("ar_data_valid", data_valid, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_bit_count", bit_count, 3'd0);
        chk("ar_overrun", overrun, 1'b0);
        idle();
        clr_n = 1'b1;
        data_ready = 1'b1;
        idle();
        send_bits(8'hC3, 1'b0, 0, 8);
        chk("ar_word_out", data_out, 8'hC3);
        chk("ar_word_valid", data_valid, 1'b1);
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
